hazard_forward_unit: RTL and testbench

// Parametrised forwarding + load-use hazard unit for the 5-stage pipeline.

---
 rtl/hazard_forward_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding-select precompute and load-use hazard control for the 5-stage pipeline.
//
// Forwarding selects are resolved in ID from the instructions that will sit in
// EX/MEM and MEM/WB when the current ID instruction reaches EX. The selects are
// then flopped, so the EX stage sees a registered mux control.
//
// Load-use stall FSM:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no hazard in flight; stall follows the live load-use compare
//   ST_STALL | extra bubbles for LOAD_LAT>1; cnt holds the bubbles still owed
//
// Select encoding per source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
module hazard_forward_unit #(
    parameter int REG_BITS = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_FWD = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hold,
    input  logic [NUM_SRC*REG_BITS-1:0]  id_src,
    input  logic [NUM_SRC-1:0]           id_src_used,
    input  logic [REG_BITS-1:0]          id_ex_rd,
    input  logic                         id_ex_regwrite,
    input  logic                         id_ex_memread,
    input  logic [REG_BITS-1:0]          ex_mem_rd,
    input  logic                         ex_mem_regwrite,
    output logic [2*NUM_SRC-1:0]         src_mux,
    output logic                         stall,
    output logic                         idex_bubble
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Three bits cover the full legal LOAD_LAT range of 1..4.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);
    localparam logic       ZERO_OK  = (ZERO_FWD != 0);
    localparam logic       MULTI    = (LOAD_LAT > 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    logic [NUM_SRC-1:0]   hit_ex;
    logic [NUM_SRC-1:0]   hit_mem;
    logic [2*NUM_SRC-1:0] mux_pre;
    logic                 load_use;

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           cnt;
    logic [2:0]           cnt_nxt;

    // Per-source match against ID/EX and EX/MEM destinations; ID/EX wins
    // because it is the younger producer and will be in EX/MEM next cycle.
    always_comb begin
        hit_ex   = '0;
        hit_mem  = '0;
        mux_pre  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            hit_ex[k]  = id_ex_regwrite & id_src_used[k]
                       & (id_src[k*REG_BITS +: REG_BITS] == id_ex_rd)
                       & ((id_ex_rd != '0) | ZERO_OK);
            hit_mem[k] = ex_mem_regwrite & id_src_used[k]
                       & (id_src[k*REG_BITS +: REG_BITS] == ex_mem_rd)
                       & ((ex_mem_rd != '0) | ZERO_OK);
            if (hit_ex[k]) begin
                mux_pre[2*k +: 2] = SEL_EXM;
            end else if (hit_mem[k]) begin
                mux_pre[2*k +: 2] = SEL_MWB;
            end else begin
                mux_pre[2*k +: 2] = SEL_RF;
            end
        end
        load_use = id_ex_memread & (|hit_ex);
    end

    // FSM state and bubble counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and stall decode. The detection cycle itself is the first
    // bubble, so ST_STALL only covers the remaining LOAD_LAT-1 cycles. hold
    // freezes the FSM but never masks stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = load_use;
                if (load_use && !hold && MULTI) begin
                    state_nxt = ST_STALL;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_STALL: begin
                // ID is held here, so a fresh load-use compare is meaningless
                // until we are back in ST_IDLE.
                stall = 1'b1;
                if (!hold) begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign idex_bubble = stall;

    // Registered forwarding select: frozen on hold, cleared when a bubble
    // enters EX, otherwise the precomputed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_mux <= '0;
        end else if (!hold) begin
            if (stall) begin
                src_mux <= '0;
            end else begin
                src_mux <= mux_pre;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: three instances (LOAD_LAT 1/2/3) share one directed stimulus
// stream; the stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_hazard_forward_unit;

    localparam int RB = 5;
    localparam int NS = 2;

    logic              clk;
    logic              rst_n;
    logic              hold;
    logic [NS*RB-1:0]  id_src;
    logic [NS-1:0]     id_src_used;
    logic [RB-1:0]     id_ex_rd;
    logic              id_ex_regwrite;
    logic              id_ex_memread;
    logic [RB-1:0]     ex_mem_rd;
    logic              ex_mem_regwrite;

    logic [3:0]        mux_a, mux_b, mux_c;
    logic              stall_a, stall_b, stall_c;
    logic              bub_a, bub_b, bub_c;

    typedef struct {
        string           name;
        logic [2:0]      stall;
        logic [2:0][3:0] mux;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_BITS(RB), .NUM_SRC(NS), .LOAD_LAT(1), .ZERO_FWD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_src(id_src), .id_src_used(id_src_used),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .src_mux(mux_a), .stall(stall_a), .idex_bubble(bub_a)
    );

    hazard_forward_unit #(.REG_BITS(RB), .NUM_SRC(NS), .LOAD_LAT(2), .ZERO_FWD(0)) u_b (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_src(id_src), .id_src_used(id_src_used),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .src_mux(mux_b), .stall(stall_b), .idex_bubble(bub_b)
    );

    hazard_forward_unit #(.REG_BITS(RB), .NUM_SRC(NS), .LOAD_LAT(3), .ZERO_FWD(0)) u_c (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_src(id_src), .id_src_used(id_src_used),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .src_mux(mux_c), .stall(stall_c), .idex_bubble(bub_c)
    );

    task automatic compare(input string nm, input string what, input int inst,
                           input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s inst%0d actual=%b required=%b", nm, what, inst, act, req);
        end
    endtask

    // Monitor: compares every pending expectation against the live outputs.
    initial begin
        exp_t       e;
        logic [2:0] st_v;
        logic [2:0] bb_v;
        logic [2:0][3:0] mx_v;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) begin
                e    = sb.pop_front();
                st_v = {stall_c, stall_b, stall_a};
                bb_v = {bub_c, bub_b, bub_a};
                mx_v = {mux_c, mux_b, mux_a};
                for (int i = 0; i < 3; i++) begin
                    compare(e.name, "stall", i, {3'b000, st_v[i]}, {3'b000, e.stall[i]});
                    compare(e.name, "idex_bubble", i, {3'b000, bb_v[i]}, {3'b000, e.stall[i]});
                    compare(e.name, "src_mux", i, mx_v[i], e.mux[i]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] exrd, input logic exwe, input logic exmr,
                         input logic [4:0] mmrd, input logic mmwe, input logic hd);
        id_src          = {s1, s0};
        id_src_used     = used;
        id_ex_rd        = exrd;
        id_ex_regwrite  = exwe;
        id_ex_memread   = exmr;
        ex_mem_rd       = mmrd;
        ex_mem_regwrite = mmwe;
        hold            = hd;
    endtask

    // st bit0 = LOAD_LAT 1, bit1 = LOAD_LAT 2, bit2 = LOAD_LAT 3
    task automatic expect_cyc(input string nm, input logic [2:0] st,
                              input logic [3:0] ma, input logic [3:0] mb, input logic [3:0] mc);
        exp_t e;
        e.name   = nm;
        e.stall  = st;
        e.mux[0] = ma;
        e.mux[1] = mb;
        e.mux[2] = mc;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        cyc(); expect_cyc("reset", 3'b000, 4'h0, 4'h0, 4'h0);

        // ID/EX add r3, EX/MEM writes r7, ID reads r3/r7
        cyc(); rst_n = 1'b1;
        drive(5'd3, 5'd7, 2'b11, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        expect_cyc("fwd_both_det", 3'b000, 4'h0, 4'h0, 4'h0);

        // both stages write r5; ID/EX must win
        cyc(); drive(5'd5, 5'd9, 2'b11, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        expect_cyc("fwd_both", 3'b000, 4'b1001, 4'b1001, 4'b1001);

        // load to r0 with r0 reads: no forward, no stall
        cyc(); drive(5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        expect_cyc("exmem_priority", 3'b000, 4'b0001, 4'b0001, 4'b0001);

        // matching indices but sources not read
        cyc(); drive(5'd6, 5'd2, 2'b00, 5'd6, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
        expect_cyc("reg0_nofwd", 3'b000, 4'h0, 4'h0, 4'h0);

        // lw r4 in ID/EX, ID rt=r4
        cyc(); drive(5'd1, 5'd4, 2'b11, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        expect_cyc("unused_src", 3'b111, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd1, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        expect_cyc("lu_cycle2", 3'b110, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd1, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_cyc("lu_cycle3", 3'b100, 4'b1000, 4'h0, 4'h0);

        // ALU producer r8 to give a non-zero select going into hold
        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_cyc("lu_done", 3'b000, 4'h0, 4'h0, 4'h0);

        // load-use r8 detected while hold is high: FSM and select frozen
        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        expect_cyc("hold_det1", 3'b111, 4'b0001, 4'b0001, 4'b0001);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        expect_cyc("hold_det2", 3'b111, 4'b0001, 4'b0001, 4'b0001);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_cyc("hold_release", 3'b111, 4'b0001, 4'b0001, 4'b0001);

        // hold for 2 cycles inside ST_STALL
        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        expect_cyc("stall_hold1", 3'b110, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        expect_cyc("stall_hold2", 3'b110, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        expect_cyc("stall_run", 3'b110, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_cyc("stall_tail", 3'b100, 4'b0010, 4'h0, 4'h0);

        cyc(); drive(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_cyc("stall_over", 3'b000, 4'h0, 4'h0, 4'h0);

        // reset in the middle of a LOAD_LAT=3 hazard (its second stall cycle)
        cyc(); drive(5'd4, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_cyc("rst_lu_det", 3'b111, 4'h0, 4'h0, 4'h0);

        cyc(); drive(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        expect_cyc("rst_lu_c2", 3'b110, 4'h0, 4'h0, 4'h0);

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expect_cyc("rst_mid_stall", 3'b000, 4'h0, 4'h0, 4'h0);
        ->chk_ev;

        cyc(); rst_n = 1'b1;
        drive(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_cyc("post_rst1", 3'b000, 4'h0, 4'h0, 4'h0);

        cyc(); expect_cyc("post_rst2", 3'b000, 4'h0, 4'h0, 4'h0);

        cyc();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
